// File: rtl/safety_irq_distributor.sv
// Interrupt distributor for the safety island.
// Takes one arbitrated interrupt from the core-local interrupt controller and
// presents it as one-hot lines to NumCores cores, either broadcast (lockstep)
// or to a single selected core (split). Per-core acks are collected, their ids
// checked, and an ack-skew timeout bounds how long the slowest core may lag.
// A single ready pulse tells the controller the interrupt was consumed.
module safety_irq_distributor #(
   parameter int NumIrqs    = 256,
   parameter int NumCores   = 3,
   parameter int LevelWidth = 8,
   parameter int AckTimeout = 64,
   localparam int IdWidth   = $clog2(NumIrqs),
   localparam int SelWidth  = (NumCores > 1) ? $clog2(NumCores) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 lockstep_i,
   input  logic [SelWidth-1:0]                  target_i,
   input  logic                                 irq_valid_i,
   input  logic [IdWidth-1:0]                   irq_id_i,
   input  logic [LevelWidth-1:0]                irq_level_i,
   input  logic                                 irq_shv_i,
   output logic                                 irq_ready_o,
   output logic [NumCores-1:0][NumIrqs-1:0]     core_irq_o,
   output logic [NumCores-1:0][LevelWidth-1:0]  core_irq_level_o,
   output logic [NumCores-1:0]                  core_irq_shv_o,
   input  logic [NumCores-1:0]                  core_ack_i,
   input  logic [NumCores-1:0][IdWidth-1:0]     core_ack_id_i,
   input  logic                                 err_clear_i,
   output logic                                 err_mismatch_o,
   output logic                                 err_timeout_o
);

   // Counter must be able to hold AckTimeout-1, the last value before timeout.
   localparam int CntWidth = $clog2(AckTimeout + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      DRAIN   = 2'd2
   } state_e;

   state_e                  state_reg, state_next;
   logic [IdWidth-1:0]      id_reg, id_next;
   logic [LevelWidth-1:0]   level_reg, level_next;
   logic                    shv_reg, shv_next;
   logic [NumCores-1:0]     target_reg, target_next;
   logic [NumCores-1:0]     acked_reg, acked_next;
   logic [CntWidth-1:0]     cnt_reg, cnt_next;
   logic                    err_mismatch_reg, err_mismatch_next;
   logic                    err_timeout_reg, err_timeout_next;

   logic [NumIrqs-1:0]      id_onehot;
   logic [NumCores-1:0]     line_on;
   logic [NumCores-1:0]     ack_accept;
   logic [NumCores-1:0]     ack_bad;
   logic [NumCores-1:0]     acked_all;
   logic [NumCores-1:0]     target_capture;
   logic                    complete;
   logic                    timeout_hit;
   logic                    timeout_set;

   assign id_onehot = NumIrqs'(1) << id_reg;

   // Per-core presentation and ack qualification: a core sees the interrupt
   // only while it is targeted and has not acked; only such cores may ack.
   for (genvar gi = 0; gi < NumCores; gi++) begin : g_core
      assign line_on[gi]          = (state_reg == PRESENT) && target_reg[gi] && !acked_reg[gi];
      assign core_irq_o[gi]       = line_on[gi] ? id_onehot : '0;
      assign core_irq_level_o[gi] = line_on[gi] ? level_reg : '0;
      assign core_irq_shv_o[gi]   = line_on[gi] && shv_reg;
      assign ack_accept[gi]       = line_on[gi] && core_ack_i[gi];
      assign ack_bad[gi]          = ack_accept[gi] && (core_ack_id_i[gi] != id_reg);
   end

   assign err_mismatch_o = err_mismatch_reg;
   assign err_timeout_o  = err_timeout_reg;

   // State and capture registers; async reset drops every output at once
   // because all core-facing outputs are decoded from state_reg.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg        <= IDLE;
         id_reg           <= '0;
         level_reg        <= '0;
         shv_reg          <= 1'b0;
         target_reg       <= '0;
         acked_reg        <= '0;
         cnt_reg          <= '0;
         err_mismatch_reg <= 1'b0;
         err_timeout_reg  <= 1'b0;
      end else begin
         state_reg        <= state_next;
         id_reg           <= id_next;
         level_reg        <= level_next;
         shv_reg          <= shv_next;
         target_reg       <= target_next;
         acked_reg        <= acked_next;
         cnt_reg          <= cnt_next;
         err_mismatch_reg <= err_mismatch_next;
         err_timeout_reg  <= err_timeout_next;
      end
   end

   // Next-state, capture, ack bookkeeping, timeout and ready generation.
   always_comb begin
      state_next        = state_reg;
      id_next           = id_reg;
      level_next        = level_reg;
      shv_next          = shv_reg;
      target_next       = target_reg;
      acked_next        = acked_reg;
      cnt_next          = cnt_reg;
      irq_ready_o       = 1'b0;
      timeout_set       = 1'b0;
      target_capture    = NumCores'(1);

      // Out-of-range split targets fall back to core 0.
      if (lockstep_i) begin
         target_capture = '1;
      end else if (int'(target_i) < NumCores) begin
         target_capture = NumCores'(1) << target_i;
      end

      acked_all   = acked_reg | ack_accept;
      complete    = (acked_all == target_reg);
      timeout_hit = (|acked_reg) && (cnt_reg == CntWidth'(AckTimeout - 1));

      case (state_reg)
         IDLE: begin
            if (irq_valid_i) begin
               id_next     = irq_id_i;
               level_next  = irq_level_i;
               shv_next    = irq_shv_i;
               target_next = target_capture;
               acked_next  = '0;
               cnt_next    = '0;
               state_next  = PRESENT;
            end
         end
         PRESENT: begin
            acked_next = acked_all;
            if (complete) begin
               // Completion beats a timeout landing in the same cycle.
               irq_ready_o = 1'b1;
               state_next  = DRAIN;
            end else if (|acked_reg) begin
               // Skew window running: upstream changes no longer matter.
               if (timeout_hit) begin
                  timeout_set = 1'b1;
                  irq_ready_o = 1'b1;
                  state_next  = DRAIN;
               end else begin
                  cnt_next = cnt_reg + CntWidth'(1);
               end
            end else if (|ack_accept) begin
               // First ack this cycle opens the skew window at zero.
               cnt_next = '0;
            end else if (!irq_valid_i || (irq_id_i != id_reg)) begin
               // Nobody took it yet: controller withdrew or preempted.
               state_next = IDLE;
            end
         end
         DRAIN: begin
            acked_next = '0;
            cnt_next   = '0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Sticky errors: a new event in the clearing cycle keeps the flag set.
      if (|ack_bad) begin
         err_mismatch_next = 1'b1;
      end else if (err_clear_i) begin
         err_mismatch_next = 1'b0;
      end else begin
         err_mismatch_next = err_mismatch_reg;
      end

      if (timeout_set) begin
         err_timeout_next = 1'b1;
      end else if (err_clear_i) begin
         err_timeout_next = 1'b0;
      end else begin
         err_timeout_next = err_timeout_reg;
      end
   end

endmodule

// File: tb/tb_safety_irq_distributor.sv
// Directed bench for safety_irq_distributor (3 cores, 256 ids, AckTimeout=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge, so the combinational ready pulse is visible mid-cycle.
module tb_safety_irq_distributor;

   logic                  clk;
   logic                  rst_n;
   logic                  lockstep;
   logic [1:0]            target;
   logic                  irq_valid;
   logic [7:0]            irq_id;
   logic [7:0]            irq_level;
   logic                  irq_shv;
   logic                  irq_ready;
   logic [2:0][255:0]     core_irq;
   logic [2:0][7:0]       core_irq_level;
   logic [2:0]            core_irq_shv;
   logic [2:0]            core_ack;
   logic [2:0][7:0]       core_ack_id;
   logic                  err_clear;
   logic                  err_mismatch;
   logic                  err_timeout;

   logic [2:0][255:0]     exp_irq;
   int                    checks;
   int                    errors;

   safety_irq_distributor #(
      .NumIrqs    (256),
      .NumCores   (3),
      .LevelWidth (8),
      .AckTimeout (8)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .lockstep_i       (lockstep),
      .target_i         (target),
      .irq_valid_i      (irq_valid),
      .irq_id_i         (irq_id),
      .irq_level_i      (irq_level),
      .irq_shv_i        (irq_shv),
      .irq_ready_o      (irq_ready),
      .core_irq_o       (core_irq),
      .core_irq_level_o (core_irq_level),
      .core_irq_shv_o   (core_irq_shv),
      .core_ack_i       (core_ack),
      .core_ack_id_i    (core_ack_id),
      .err_clear_i      (err_clear),
      .err_mismatch_o   (err_mismatch),
      .err_timeout_o    (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      lockstep    = 1'b0;
      target      = 2'd0;
      irq_valid   = 1'b0;
      irq_id      = 8'd0;
      irq_level   = 8'd0;
      irq_shv     = 1'b0;
      core_ack    = 3'b000;
      core_ack_id = '0;
      err_clear   = 1'b0;
      #22;
      checks++;
      if (core_irq !== '0) begin
         errors++;
         $display("FAIL reset_core_irq: got %h required 0", core_irq);
      end
      checks++;
      if ({irq_ready, err_mismatch, err_timeout, core_irq_shv} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000000",
                  {irq_ready, err_mismatch, err_timeout, core_irq_shv});
      end
      checks++;
      if (core_irq_level !== '0) begin
         errors++;
         $display("FAIL reset_level: got %h required 0", core_irq_level);
      end
      mid();
      rst_n = 1'b1;
      cyc();
      $display("reset: released");
   endtask

   task automatic test_lockstep();
      lockstep  = 1'b1;
      irq_valid = 1'b1;
      irq_id    = 8'd17;
      irq_level = 8'd5;
      irq_shv   = 1'b1;
      mid();
      checks++;
      if (core_irq !== '0) begin
         errors++;
         $display("FAIL ls_before_capture: got %h required 0", core_irq);
      end
      cyc();
      // C1: broadcast visible on all three cores
      mid();
      exp_irq = '0;
      exp_irq[0][17] = 1'b1;
      exp_irq[1][17] = 1'b1;
      exp_irq[2][17] = 1'b1;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL ls_present: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (core_irq_level !== {8'd5, 8'd5, 8'd5}) begin
         errors++;
         $display("FAIL ls_level: got %h required 050505", core_irq_level);
      end
      checks++;
      if (core_irq_shv !== 3'b111) begin
         errors++;
         $display("FAIL ls_shv: got %b required 111", core_irq_shv);
      end
      cyc();
      // C2: core 0 acks
      core_ack    = 3'b001;
      core_ack_id = {8'd17, 8'd17, 8'd17};
      mid();
      checks++;
      if (irq_ready !== 1'b0) begin
         errors++;
         $display("FAIL ls_ready_partial: got %b required 0", irq_ready);
      end
      cyc();
      // C3: cores 1 and 2 ack, completing
      core_ack = 3'b110;
      mid();
      exp_irq[0] = '0;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL ls_core0_dropped: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (core_irq_level !== {8'd5, 8'd5, 8'd0}) begin
         errors++;
         $display("FAIL ls_level_partial: got %h required 050500", core_irq_level);
      end
      checks++;
      if (irq_ready !== 1'b1) begin
         errors++;
         $display("FAIL ls_ready: got %b required 1", irq_ready);
      end
      cyc();
      // C4: drain
      core_ack  = 3'b000;
      irq_valid = 1'b0;
      mid();
      checks++;
      if ({core_irq !== '0, irq_ready, err_mismatch, err_timeout} !== 4'b0) begin
         errors++;
         $display("FAIL ls_drain: got irq_nonzero/ready/mis/to=%b required 0000",
                  {core_irq !== '0, irq_ready, err_mismatch, err_timeout});
      end
      cyc();
      $display("lockstep: id=17 level=5 delivered to 3 cores");
   endtask

   task automatic test_split();
      lockstep    = 1'b0;
      target      = 2'd2;
      irq_valid   = 1'b1;
      irq_id      = 8'd200;
      irq_level   = 8'd9;
      irq_shv     = 1'b0;
      cyc();
      // C1: only core 2; a stray ack from core 0 must be ignored
      core_ack       = 3'b001;
      core_ack_id[0] = 8'd200;
      mid();
      exp_irq = '0;
      exp_irq[2][200] = 1'b1;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL split_present: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (core_irq_level !== {8'd9, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL split_level: got %h required 090000", core_irq_level);
      end
      checks++;
      if (irq_ready !== 1'b0) begin
         errors++;
         $display("FAIL split_stray_ack: got ready %b required 0", irq_ready);
      end
      cyc();
      // C2: core 2 acks
      core_ack       = 3'b100;
      core_ack_id[2] = 8'd200;
      mid();
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL split_still_present: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (irq_ready !== 1'b1) begin
         errors++;
         $display("FAIL split_ready: got %b required 1", irq_ready);
      end
      cyc();
      // C3: drain must ignore the new valid
      core_ack = 3'b000;
      target   = 2'd3;
      irq_id   = 8'd55;
      mid();
      checks++;
      if (core_irq !== '0) begin
         errors++;
         $display("FAIL split_drain: got %h required 0", core_irq);
      end
      cyc();
      // C4: idle, capturing id 55 with out-of-range target
      mid();
      checks++;
      if (core_irq !== '0) begin
         errors++;
         $display("FAIL split_idle_after_drain: got %h required 0", core_irq);
      end
      cyc();
      // C5: delivered to core 0
      core_ack       = 3'b001;
      core_ack_id[0] = 8'd55;
      mid();
      exp_irq = '0;
      exp_irq[0][55] = 1'b1;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL split_target3: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (irq_ready !== 1'b1) begin
         errors++;
         $display("FAIL split_target3_ready: got %b required 1", irq_ready);
      end
      cyc();
      core_ack  = 3'b000;
      irq_valid = 1'b0;
      mid();
      checks++;
      if (err_mismatch !== 1'b0) begin
         errors++;
         $display("FAIL split_no_mismatch: got %b required 0", err_mismatch);
      end
      cyc();
      $display("split: id=200 to core 2, id=55 target 3 to core 0");
   endtask

   task automatic test_retract();
      lockstep  = 1'b1;
      irq_valid = 1'b1;
      irq_id    = 8'd9;
      irq_level = 8'd3;
      cyc();
      // C1: id 9 presented, controller preempts with id 4
      irq_id = 8'd4;
      mid();
      exp_irq = '0;
      exp_irq[0][9] = 1'b1;
      exp_irq[1][9] = 1'b1;
      exp_irq[2][9] = 1'b1;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL retract_present9: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (irq_ready !== 1'b0) begin
         errors++;
         $display("FAIL retract_no_ready: got %b required 0", irq_ready);
      end
      cyc();
      // C2: back in IDLE
      mid();
      checks++;
      if (core_irq !== '0) begin
         errors++;
         $display("FAIL retract_idle: got %h required 0", core_irq);
      end
      cyc();
      // C3: id 4 presented and acked by all
      core_ack    = 3'b111;
      core_ack_id = {8'd4, 8'd4, 8'd4};
      mid();
      exp_irq = '0;
      exp_irq[0][4] = 1'b1;
      exp_irq[1][4] = 1'b1;
      exp_irq[2][4] = 1'b1;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL retract_present4: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (irq_ready !== 1'b1) begin
         errors++;
         $display("FAIL retract_ready4: got %b required 1", irq_ready);
      end
      cyc();
      core_ack  = 3'b000;
      irq_valid = 1'b0;
      cyc();
      $display("retract: id=9 withdrawn, id=4 delivered");
   endtask

   task automatic test_mismatch();
      lockstep  = 1'b1;
      irq_valid = 1'b1;
      irq_id    = 8'd30;
      cyc();
      core_ack    = 3'b111;
      core_ack_id = {8'd30, 8'd31, 8'd30};
      mid();
      checks++;
      if (irq_ready !== 1'b1) begin
         errors++;
         $display("FAIL mis_ready: got %b required 1", irq_ready);
      end
      cyc();
      core_ack  = 3'b000;
      irq_valid = 1'b0;
      mid();
      checks++;
      if (err_mismatch !== 1'b1) begin
         errors++;
         $display("FAIL mis_set: got %b required 1", err_mismatch);
      end
      cyc();
      err_clear = 1'b1;
      mid();
      checks++;
      if (err_mismatch !== 1'b1) begin
         errors++;
         $display("FAIL mis_sticky: got %b required 1", err_mismatch);
      end
      cyc();
      err_clear = 1'b0;
      mid();
      checks++;
      if (err_mismatch !== 1'b0) begin
         errors++;
         $display("FAIL mis_clear: got %b required 0", err_mismatch);
      end
      cyc();
      $display("mismatch: core 1 acked 31 for id 30, flagged and cleared");
   endtask

   // late_core2 = 1 acks core 2 exactly on the timeout cycle.
   task automatic test_timeout(input logic late_core2);
      lockstep    = 1'b1;
      irq_valid   = 1'b1;
      irq_id      = 8'd77;
      core_ack_id = {8'd77, 8'd77, 8'd77};
      cyc();
      // C1: cores 0 and 1 ack
      core_ack = 3'b011;
      mid();
      checks++;
      if (irq_ready !== 1'b0) begin
         errors++;
         $display("FAIL to_first_ack_ready: got %b required 0", irq_ready);
      end
      cyc();
      core_ack = 3'b000;
      // C2..C8: waiting on core 2
      for (int k = 2; k <= 8; k++) begin
         mid();
         checks++;
         if (irq_ready !== 1'b0) begin
            errors++;
            $display("FAIL to_wait_c%0d: got ready %b required 0", k, irq_ready);
         end
         cyc();
      end
      // C9: timeout cycle
      if (late_core2) core_ack = 3'b100;
      mid();
      exp_irq = '0;
      exp_irq[2][77] = 1'b1;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL to_core2_only: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (irq_ready !== 1'b1) begin
         errors++;
         $display("FAIL to_ready: got %b required 1", irq_ready);
      end
      cyc();
      // C10: drain
      core_ack  = 3'b000;
      irq_valid = 1'b0;
      mid();
      checks++;
      if (err_timeout !== !late_core2) begin
         errors++;
         $display("FAIL to_err(late=%0b): got %b required %b", late_core2, err_timeout, !late_core2);
      end
      checks++;
      if (core_irq !== '0) begin
         errors++;
         $display("FAIL to_drain: got %h required 0", core_irq);
      end
      cyc();
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      mid();
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_clear: got %b required 0", err_timeout);
      end
      cyc();
      $display("timeout: id=77 late_core2=%0b", late_core2);
   endtask

   task automatic test_reset_mid();
      lockstep  = 1'b1;
      irq_valid = 1'b1;
      irq_id    = 8'd12;
      irq_level = 8'd7;
      core_ack_id = {8'd12, 8'd12, 8'd12};
      cyc();
      core_ack = 3'b001;
      cyc();
      core_ack = 3'b000;
      mid();
      exp_irq = '0;
      exp_irq[1][12] = 1'b1;
      exp_irq[2][12] = 1'b1;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL rst_partial: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (core_irq_level !== {8'd7, 8'd7, 8'd0}) begin
         errors++;
         $display("FAIL rst_partial_level: got %h required 070700", core_irq_level);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (core_irq !== '0) begin
         errors++;
         $display("FAIL rst_async_irq: got %h required 0", core_irq);
      end
      checks++;
      if ({irq_ready, core_irq_shv, core_irq_level !== '0} !== 5'b0) begin
         errors++;
         $display("FAIL rst_async_other: got %b required 00000",
                  {irq_ready, core_irq_shv, core_irq_level !== '0});
      end
      irq_id = 8'd99;
      cyc();
      mid();
      rst_n = 1'b1;
      cyc();
      core_ack    = 3'b111;
      core_ack_id = {8'd99, 8'd99, 8'd99};
      mid();
      exp_irq = '0;
      exp_irq[0][99] = 1'b1;
      exp_irq[1][99] = 1'b1;
      exp_irq[2][99] = 1'b1;
      checks++;
      if (core_irq !== exp_irq) begin
         errors++;
         $display("FAIL rst_recapture: got %h required %h", core_irq, exp_irq);
      end
      checks++;
      if (irq_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_recapture_ready: got %b required 1", irq_ready);
      end
      cyc();
      core_ack  = 3'b000;
      irq_valid = 1'b0;
      cyc();
      $display("reset_mid: partial acks discarded, id=99 recaptured");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_lockstep();
      test_split();
      test_retract();
      test_mismatch();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/safety_irq_distributor.md
Name: safety_irq_distributor

Overview:
- Parametrised successor to the single-core interrupt glue between the core-local interrupt controller and the safety cores.
- Accepts one arbitrated interrupt (id/level/shv, valid/ready) and presents it as one-hot lines to NumCores cores.
- Lockstep mode: broadcast to all cores. Split mode: deliver to one selected core.
- Collects per-core acknowledges, checks ack ids, runs an ack-skew timeout, and returns a single ready to the controller. Prepares the island for TCLS.

Parameters:
- NumIrqs, 256, interrupt sources; IdWidth = $clog2(NumIrqs).
- NumCores, 3, cores served; SelWidth = max(1, $clog2(NumCores)).
- LevelWidth, 8, interrupt level width.
- AckTimeout, 64, max cycles from first ack to last required ack (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- lockstep_i  in  1  1 = broadcast to all cores; sampled at capture
- target_i  in  SelWidth  split-mode destination core; sampled at capture
- irq_valid_i  in  1  controller interrupt valid
- irq_id_i  in  IdWidth  interrupt id
- irq_level_i  in  LevelWidth  interrupt level
- irq_shv_i  in  1  selective hardware vectoring
- irq_ready_o  out  1  one-cycle pulse: interrupt consumed
- core_irq_o  out  NumCores x NumIrqs  per-core one-hot interrupt lines
- core_irq_level_o  out  NumCores x LevelWidth  per-core level
- core_irq_shv_o  out  NumCores  per-core shv
- core_ack_i  in  NumCores  per-core ack pulse
- core_ack_id_i  in  NumCores x IdWidth  id acknowledged by each core
- err_clear_i  in  1  clears sticky errors
- err_mismatch_o  out  1  sticky: ack id differed from presented id
- err_timeout_o  out  1  sticky: ack skew exceeded AckTimeout

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0; internal id/level/shv/target mask/acked mask/counter cleared.
- State IDLE:
  - If irq_valid_i: capture id, level, shv.
  - Target mask = all ones if lockstep_i, else one-hot(target_i). If target_i >= NumCores, use core 0.
  - Next state PRESENT. Latency valid -> core_irq_o is 1 cycle.
- State PRESENT:
  - For each targeted core not yet acked: core_irq_o[c][id] = 1; level and shv driven. All other lines 0.
  - Ack accepted only from cores in target mask and not yet acked; set acked bit. Other acks ignored.
  - Accepted ack with core_ack_id_i[c] != captured id sets err_mismatch_o. The ack still counts, so the block cannot deadlock.
  - Retract: if no core has acked yet and (irq_valid_i = 0 or irq_id_i != captured id), go to IDLE with no ready pulse. The controller may preempt with a higher-priority interrupt. Once any ack is accepted, upstream changes are ignored.
  - Complete: when acked mask (including this cycle's acks) equals target mask, pulse irq_ready_o and go to DRAIN.
  - Timeout counter: starts at 0 on the first accepted ack and increments each cycle while incomplete. On reaching AckTimeout: set err_timeout_o, pulse irq_ready_o, go to DRAIN. Completion in the same cycle as timeout wins; no error.
- State DRAIN: all core outputs 0 for one cycle, ignore irq_valid_i, then go to IDLE. This gives the controller a cycle to update valid/id after ready.
- Simultaneous acks from several cores in one cycle are all accepted.
- lockstep_i and target_i changes outside IDLE capture have no effect.
- Sticky errors clear on err_clear_i. A set event in the same cycle as the clear wins.
- NumCores = 1: lockstep and split behave identically; the timeout never fires.
- Async reset mid-PRESENT: outputs drop to 0 immediately; no ready pulse.

Test Plan:
1. Lockstep, NumCores=3: irq_valid_i=1, id=17, level=5. Next cycle core_irq_o[0..2][17]=1, level 5. Acks from cores 0,1,2 at cycles +2,+3,+3 -> irq_ready_o pulses at the +3 edge, outputs drop to 0 in DRAIN, no errors.
2. Split mode: target_i=2, id=200 -> only core_irq_o[2][200]=1. Ack from core 0 is ignored. Ack from core 2 with id 200 -> ready pulse. With target_i=3 -> delivered to core 0.
3. Retract: present id=9, no ack; controller switches to id=4 -> back to IDLE without ready. Next capture presents id 4 after one cycle.
4. Mismatch: lockstep id=30; core 1 acks id 31, others ack id 30 -> err_mismatch_o=1 sticky, ready still pulses. err_clear_i -> 0.
5. Timeout: AckTimeout=8, lockstep; only cores 0 and 1 ack -> 8 cycles after the first ack, err_timeout_o=1, ready pulses, DRAIN, IDLE. Variant where core 2 acks exactly at cycle 8 -> no error.
6. Reset in PRESENT with partial acks -> all outputs 0 asynchronously; after release, a new valid is captured normally.
